bp_me_bedrock_mem_responder: RTL and testbench
==============================================

# bp_me_bedrock_mem_responder

Memory-side end of the BedRock memory interface. Accepts single-beat memory commands from a CCE or I/O master, services them against a local byte-maskable synchronous SRAM, and returns one memory response per command. Which message types carry a payload comes from the shared package masks: commands with `e_mem_msg_wr` or `e_mem_msg_uc_wr` carry write data, and responses to `e_mem_msg_rd` or `e_mem_msg_uc_rd` carry read data. Used as a backing store in unit benches and as on-chip scratch memory behind the CCE.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: selects the BedRock header layout (`mem_header_width_lp`, `paddr_width_p`).
- `data_width_p`, default 64: beat width in bits. Must be a power of two, at least 64. One command or response is exactly one beat.
- `els_p`, default 256: SRAM depth in words.
- `clk_i`, in, 1: single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `mem_cmd_header_i`, in, `mem_header_width_lp`: `bp_bedrock_mem_msg_header_s` (msg_type, addr, size, payload).
- `mem_cmd_data_i`, in, `data_width_p`: write payload, LSB-aligned.
- `mem_cmd_v_i`, in, 1: command valid.
- `mem_cmd_ready_and_o`, out, 1: command ready.
- `mem_resp_header_o`, out, `mem_header_width_lp`: response header.
- `mem_resp_data_o`, out, `data_width_p`: read payload, LSB-aligned. Zero when the response carries no payload.
- `mem_resp_v_o`, out, 1: response valid.
- `mem_resp_ready_and_i`, in, 1: response ready.

## Operation
- FSM states are `e_ready` and `e_resp`.
- Reset values:
  - state `e_ready`
  - `mem_resp_v_o` = 0
  - `mem_cmd_ready_and_o` = 1
  - response header register = 0
- SRAM contents are not cleared by reset.
- A command is accepted when `mem_cmd_v_i` and `mem_cmd_ready_and_o` are both high in the same cycle.
- `mem_cmd_ready_and_o` = (state == `e_ready`) OR (state == `e_resp` AND `mem_resp_ready_and_i`).
- On accept:
  - The header is registered.
  - The SRAM is accessed that cycle.
  - The next state is `e_resp`.
- SRAM word index = addr[lg(data_width_p/8) +: lg(els_p)]. Higher address bits are ignored, so addresses alias modulo els_p words.
- Byte offset = addr[lg(data_width_p/8)-1:0]. Byte count = 2^size, saturated at data_width_p/8.
- Write (`e_mem_msg_wr`, `e_mem_msg_uc_wr`):
  - The payload is shifted left by offset×8.
  - The byte mask covers [offset, offset+count).
  - Bytes past the word boundary are dropped; writes do not wrap into the next word.
- Read (`e_mem_msg_rd`, `e_mem_msg_uc_rd`):
  - Full-word SRAM read.
  - The response data is the word shifted right by offset×8.
  - Bytes at or above count are zeroed.
- Any other msg_type gets a header-only response with no SRAM access.
- Response header = the command header unchanged (msg_type, addr, size, payload echoed).
- `mem_resp_data_o` is nonzero only when msg_type is in `mem_resp_payload_mask_gp`.
- In `e_resp`:
  - `mem_resp_v_o` = 1.
  - On handshake with no new command, the next state is `e_ready`.
  - On handshake with a simultaneous new command accept, the FSM stays in `e_resp` (back-to-back).
- While `mem_resp_ready_and_i` is low, every response output holds stable and no SRAM access occurs.
- Reset asserted mid-operation immediately (asynchronously) drops `mem_resp_v_o` and returns the FSM to `e_ready`. The in-flight response is lost.

## Timing
- Latency: the response is valid in the cycle after command accept, for every msg_type.
- Throughput: one command per cycle with no response backpressure.
- Read data comes directly from the SRAM output, through the shift/mask logic, with no extra register.
- The SRAM output is only disturbed by a new access, and a new access happens only when the current response completes.
- A read issued in the same cycle as the handshake of a prior write to the same word returns the new data. The write took effect in its own accept cycle.

## Structure
- `mem_cmd_payload_mask_gp` and `mem_resp_payload_mask_gp` stay in `bp_me_pkg`. This block uses them and defines no new copies.
- No new typedefs; the header struct comes from the common BedRock interface include.
- One sub-module, `bsg_mem_1rw_sync_mask_write_byte` (els_p × data_width_p).
- Shift, mask and FSM logic are local.

## Test plan
- Write then read:
  - Stimulus: `e_mem_msg_wr` addr 0x80, size 8B, data 0x1122334455667788; then `e_mem_msg_rd` addr 0x80.
  - Required: two responses, each one cycle after its command. The write response has data 0; the read response returns 0x1122334455667788 with the header echoed.
- Sub-word uncached write:
  - Stimulus: `e_mem_msg_uc_wr` addr 0x83, size 1B, data 0xAB over the prior word; then `e_mem_msg_uc_rd` addr 0x80, 8B.
  - Required: read returns 0x11223344AB667788.
- Sub-word uncached read:
  - Stimulus: `e_mem_msg_uc_rd` addr 0x84, size 2B.
  - Required: data 0x0000000000003344.
- Backpressure and back-to-back:
  - Stimulus: hold `mem_resp_ready_and_i` low 5 cycles with a second command pending.
  - Required: ready low, response stable for all 5 cycles. On release, the handshake and the second accept land in the same cycle, and the second response is valid the next cycle.
- Aliasing and overflow:
  - Stimulus: els_p=256, write addr 0x800.
  - Required: it aliases word 0.
  - Stimulus: `e_mem_msg_uc_wr` addr 0x87, size 4B.
  - Required: only byte 7 is written; the next word is unchanged.
- Reset mid-response:
  - Stimulus: deassert `reset_n_i` while `mem_resp_v_o`=1.
  - Required: v drops with no clock edge, ready=1 after release, and prior SRAM contents are still readable.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-interface definitions: header layout, message types and
// the payload masks that say which commands/responses carry data.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int paddr_width_gp = 40;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3,
        e_mem_msg_pre   = 4'd4,
        e_mem_msg_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        bp_bedrock_mem_type_e      msg_type;
        logic [paddr_width_gp-1:0] addr;
        bp_bedrock_msg_size_e      size;
        logic [15:0]               payload;
    } bp_bedrock_mem_msg_header_s;

    typedef enum logic {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_me_responder_state_e;

    localparam logic [15:0] mem_cmd_payload_mask_gp  = (16'd1 << e_mem_msg_wr) | (16'd1 << e_mem_msg_uc_wr);
    localparam logic [15:0] mem_resp_payload_mask_gp = (16'd1 << e_mem_msg_rd) | (16'd1 << e_mem_msg_uc_rd);

    function automatic int mem_header_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_bedrock_mem_msg_header_s);
            default:          return $bits(bp_bedrock_mem_msg_header_s);
        endcase
    endfunction

    // Bytes touched by a message of 2^size bytes, clipped to one beat.
    function automatic int byte_count_f(logic [2:0] size, int lg_bytes);
        return (int'(size) >= lg_bytes) ? (1 << lg_bytes) : (1 << size);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write enables. Read data appears
// the cycle after a read access and holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int els_p        = 256,
    parameter int data_width_p = 64,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]  data_o
);

    logic [data_width_p-1:0] mem_q [els_p];
    logic [data_width_p-1:0] data_q;

    // NOTE: storage arrays get no reset; clearing them would turn the SRAM into flops.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int i = 0; i < mask_width_lp; i++) begin
                if (write_mask_i[i]) mem_q[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
            end
        end
        if (v_i && !w_i) data_q <= mem_q[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/bp_me_bedrock_mem_responder.sv
// Memory-side BedRock endpoint: one single-beat command in, one response out,
// serviced against a local byte-maskable synchronous SRAM.
module bp_me_bedrock_mem_responder
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int data_width_p = 64,
    parameter int els_p        = 256,
    localparam int mem_header_width_lp = mem_header_width_f(bp_params_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [mem_header_width_lp-1:0] mem_cmd_header_i,
    input  logic [data_width_p-1:0]        mem_cmd_data_i,
    input  logic                           mem_cmd_v_i,
    output logic                           mem_cmd_ready_and_o,
    output logic [mem_header_width_lp-1:0] mem_resp_header_o,
    output logic [data_width_p-1:0]        mem_resp_data_o,
    output logic                           mem_resp_v_o,
    input  logic                           mem_resp_ready_and_i
);

    localparam int bytes_lp    = data_width_p / 8;
    localparam int lg_bytes_lp = $clog2(bytes_lp);
    localparam int lg_els_lp   = $clog2(els_p);

    bp_me_responder_state_e     state_q, state_d;
    bp_bedrock_mem_msg_header_s cmd_hdr, hdr_q, hdr_d;

    logic                    cmd_accept, cmd_is_wr, cmd_is_rd;
    logic                    sram_v;
    logic [lg_els_lp-1:0]    sram_addr;
    logic [bytes_lp-1:0]     sram_wmask;
    logic [data_width_p-1:0] sram_wdata, sram_rdata, rsp_shifted, rsp_data;
    int                      cmd_off, cmd_cnt, rsp_off, rsp_cnt;

    assign cmd_hdr = mem_cmd_header_i;

    assign mem_cmd_ready_and_o = (state_q == e_ready) || ((state_q == e_resp) && mem_resp_ready_and_i);
    assign cmd_accept          = mem_cmd_v_i && mem_cmd_ready_and_o;

    assign cmd_is_wr = mem_cmd_payload_mask_gp[cmd_hdr.msg_type];
    assign cmd_is_rd = mem_resp_payload_mask_gp[cmd_hdr.msg_type];
    assign sram_v    = cmd_accept && (cmd_is_wr || cmd_is_rd);
    assign sram_addr = cmd_hdr.addr[lg_bytes_lp +: lg_els_lp];

    // Write path: bytes past the end of the word fall off the mask rather than wrapping.
    always_comb begin
        cmd_off    = int'(cmd_hdr.addr[lg_bytes_lp-1:0]);
        cmd_cnt    = byte_count_f(cmd_hdr.size, lg_bytes_lp);
        sram_wdata = mem_cmd_data_i << (cmd_off * 8);
        for (int i = 0; i < bytes_lp; i++) begin
            sram_wmask[i] = (i >= cmd_off) && (i < cmd_off + cmd_cnt);
        end
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (els_p),
        .data_width_p (data_width_p)
    ) mem (
        .clk_i        (clk_i),
        .v_i          (sram_v),
        .w_i          (cmd_is_wr),
        .addr_i       (sram_addr),
        .data_i       (sram_wdata),
        .write_mask_i (sram_wmask),
        .data_o       (sram_rdata)
    );

    // Read path works off the registered header, so it stays aligned with the SRAM output.
    always_comb begin
        rsp_off     = int'(hdr_q.addr[lg_bytes_lp-1:0]);
        rsp_cnt     = byte_count_f(hdr_q.size, lg_bytes_lp);
        rsp_shifted = sram_rdata >> (rsp_off * 8);
        rsp_data    = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            if (i < rsp_cnt) rsp_data[i*8 +: 8] = rsp_shifted[i*8 +: 8];
        end
    end

    assign mem_resp_v_o      = (state_q == e_resp);
    assign mem_resp_header_o = hdr_q;
    assign mem_resp_data_o   = (mem_resp_v_o && mem_resp_payload_mask_gp[hdr_q.msg_type]) ? rsp_data : '0;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        hdr_d   = cmd_accept ? cmd_hdr : hdr_q;
        case (state_q)
            e_ready: if (cmd_accept) state_d = e_resp;
            e_resp:  if (mem_resp_ready_and_i) state_d = cmd_accept ? e_resp : e_ready;
            default: state_d = e_ready;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
        end
    end

endmodule

// File: tb/tb_bp_me_bedrock_mem_responder.sv
// Bench for the BedRock memory responder: directed cases plus random traffic
// checked against a byte-level memory model.
module tb_bp_me_bedrock_mem_responder;
    import bp_me_pkg::*;

    localparam int hw = mem_header_width_f(e_bp_default_cfg);

    logic                       clk_i = 1'b0;
    logic                       reset_n_i;
    bp_bedrock_mem_msg_header_s mem_cmd_header_i;
    logic [63:0]                mem_cmd_data_i;
    logic                       mem_cmd_v_i;
    logic                       mem_cmd_ready_and_o;
    logic [hw-1:0]              mem_resp_header_raw;
    bp_bedrock_mem_msg_header_s mem_resp_header_o;
    logic [63:0]                mem_resp_data_o;
    logic                       mem_resp_v_o;
    logic                       mem_resp_ready_and_i;

    int checks_passed = 0;
    int checks_total  = 0;

    logic [63:0] model_mem [256];

    always #5 clk_i = ~clk_i;

    assign mem_resp_header_o = mem_resp_header_raw;

    bp_me_bedrock_mem_responder dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .mem_cmd_header_i     (mem_cmd_header_i),
        .mem_cmd_data_i       (mem_cmd_data_i),
        .mem_cmd_v_i          (mem_cmd_v_i),
        .mem_cmd_ready_and_o  (mem_cmd_ready_and_o),
        .mem_resp_header_o    (mem_resp_header_raw),
        .mem_resp_data_o      (mem_resp_data_o),
        .mem_resp_v_o         (mem_resp_v_o),
        .mem_resp_ready_and_i (mem_resp_ready_and_i)
    );

    function automatic bp_bedrock_mem_msg_header_s mk_hdr(bp_bedrock_mem_type_e t, logic [39:0] a,
                                                           logic [2:0] s, logic [15:0] p);
        bp_bedrock_mem_msg_header_s h;
        h.msg_type = t;
        h.addr     = a;
        h.size     = bp_bedrock_msg_size_e'(s);
        h.payload  = p;
        return h;
    endfunction

    // Byte-by-byte memory model: applies a command and returns the expected response data.
    function automatic logic [63:0] model_apply(bp_bedrock_mem_msg_header_s h, logic [63:0] d);
        int word, off, cnt;
        logic [63:0] res;
        res  = '0;
        word = int'(h.addr[10:3]);
        off  = int'(h.addr[2:0]);
        cnt  = 1 << int'(h.size);
        if (cnt > 8) cnt = 8;
        case (h.msg_type)
            e_mem_msg_wr, e_mem_msg_uc_wr:
                for (int b = 0; b < cnt; b++)
                    if (off + b < 8) model_mem[word][(off+b)*8 +: 8] = d[b*8 +: 8];
            e_mem_msg_rd, e_mem_msg_uc_rd:
                for (int b = 0; b < cnt; b++)
                    if (off + b < 8) res[b*8 +: 8] = model_mem[word][(off+b)*8 +: 8];
            default: ;
        endcase
        return res;
    endfunction

    // Drives one command with the response channel always ready; samples the response
    // one cycle after acceptance.
    task automatic do_txn(input bp_bedrock_mem_msg_header_s h, input logic [63:0] d,
                          output bp_bedrock_mem_msg_header_s rh, output logic [63:0] rdata,
                          output bit lat_ok);
        int waitc;
        @(negedge clk_i);
        mem_cmd_header_i     = h;
        mem_cmd_data_i       = d;
        mem_cmd_v_i          = 1'b1;
        mem_resp_ready_and_i = 1'b1;
        #1;
        waitc = 0;
        while (!mem_cmd_ready_and_o && waitc < 20) begin
            @(negedge clk_i);
            #1;
            waitc++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        mem_cmd_v_i = 1'b0;
        lat_ok = (waitc < 20) && (mem_resp_v_o === 1'b1);
        rh     = mem_resp_header_o;
        rdata  = mem_resp_data_o;
    endtask

    task automatic test_reset();
        reset_n_i            = 1'b0;
        mem_cmd_header_i     = '0;
        mem_cmd_data_i       = '0;
        mem_cmd_v_i          = 1'b0;
        mem_resp_ready_and_i = 1'b0;
        #2;
        checks_total++;
        if (mem_resp_v_o !== 1'b0) $display("FAIL reset_v: got %b want 0", mem_resp_v_o);
        else checks_passed++;
        checks_total++;
        if (mem_cmd_ready_and_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", mem_cmd_ready_and_o);
        else checks_passed++;
        checks_total++;
        if (mem_resp_header_raw !== '0) $display("FAIL reset_hdr: got %h want 0", mem_resp_header_raw);
        else checks_passed++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_fill();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] d, rd, exp;
        bit lat;
        for (int w = 0; w < 256; w++) begin
            h   = mk_hdr(e_mem_msg_wr, 40'(w) << 3, 3'd3, 16'($urandom));
            d   = {$urandom, $urandom};
            exp = model_apply(h, d);
            do_txn(h, d, rh, rd, lat);
            checks_total++;
            if ({lat, rh, rd} !== {1'b1, h, exp})
                $display("FAIL fill[%0d]: got v=%0b hdr=%h data=%h want v=1 hdr=%h data=%h", w, lat, rh, rd, h, exp);
            else checks_passed++;
        end
    endtask

    task automatic test_write_read();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] rd, exp;
        bit lat;
        h   = mk_hdr(e_mem_msg_wr, 40'h80, 3'd3, 16'h1234);
        exp = model_apply(h, 64'h1122334455667788);
        do_txn(h, 64'h1122334455667788, rh, rd, lat);
        checks_total++;
        if ({lat, rh, rd} !== {1'b1, h, 64'h0})
            $display("FAIL wr_resp: got v=%0b hdr=%h data=%h want v=1 hdr=%h data=0", lat, rh, rd, h);
        else checks_passed++;
        h   = mk_hdr(e_mem_msg_rd, 40'h80, 3'd3, 16'h5678);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if ({lat, rh} !== {1'b1, h})
            $display("FAIL rd_hdr: got v=%0b hdr=%h want v=1 hdr=%h", lat, rh, h);
        else checks_passed++;
        checks_total++;
        if (rd !== 64'h1122334455667788 || exp !== 64'h1122334455667788)
            $display("FAIL rd_data: got %h want %h", rd, 64'h1122334455667788);
        else checks_passed++;
    endtask

    task automatic test_subword();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] rd, exp;
        bit lat;
        h   = mk_hdr(e_mem_msg_uc_wr, 40'h83, 3'd0, 16'h0);
        exp = model_apply(h, 64'hFFFFFFFFFFFFFFAB);
        do_txn(h, 64'hFFFFFFFFFFFFFFAB, rh, rd, lat);
        checks_total++;
        if ({lat, rd} !== {1'b1, 64'h0}) $display("FAIL ucwr_resp: got v=%0b data=%h want v=1 data=0", lat, rd);
        else checks_passed++;
        h   = mk_hdr(e_mem_msg_uc_rd, 40'h80, 3'd3, 16'h0);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if (rd !== 64'h11223344AB667788 || exp !== 64'h11223344AB667788)
            $display("FAIL ucwr_merge: got %h want %h", rd, 64'h11223344AB667788);
        else checks_passed++;
        h   = mk_hdr(e_mem_msg_uc_rd, 40'h84, 3'd1, 16'h0);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if ({lat, rd} !== {1'b1, 64'h3344})
            $display("FAIL ucrd_sub: got v=%0b data=%h want v=1 data=%h", lat, rd, 64'h3344);
        else checks_passed++;
    endtask

    task automatic test_alias_overflow();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] rd, exp, d;
        bit lat;
        d   = {$urandom, $urandom};
        h   = mk_hdr(e_mem_msg_wr, 40'h800, 3'd3, 16'h0);
        exp = model_apply(h, d);
        do_txn(h, d, rh, rd, lat);
        h   = mk_hdr(e_mem_msg_rd, 40'h0, 3'd3, 16'h0);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if (rd !== d) $display("FAIL alias: got %h want %h", rd, d);
        else checks_passed++;
        h   = mk_hdr(e_mem_msg_uc_wr, 40'h87, 3'd2, 16'h0);
        exp = model_apply(h, 64'hDDCCBBAA);
        do_txn(h, 64'hDDCCBBAA, rh, rd, lat);
        h   = mk_hdr(e_mem_msg_rd, 40'h80, 3'd3, 16'h0);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if (rd !== 64'hAA223344AB667788) $display("FAIL overflow_word: got %h want %h", rd, 64'hAA223344AB667788);
        else checks_passed++;
        h   = mk_hdr(e_mem_msg_rd, 40'h88, 3'd3, 16'h0);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if (rd !== exp) $display("FAIL overflow_next: got %h want %h", rd, exp);
        else checks_passed++;
    endtask

    task automatic test_other_type();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] rd, exp;
        bit lat;
        h   = mk_hdr(e_mem_msg_pre, 40'h80, 3'd3, 16'hBEEF);
        exp = model_apply(h, 64'hFFFF0000FFFF0000);
        do_txn(h, 64'hFFFF0000FFFF0000, rh, rd, lat);
        checks_total++;
        if ({lat, rh, rd} !== {1'b1, h, 64'h0})
            $display("FAIL other_resp: got v=%0b hdr=%h data=%h want v=1 hdr=%h data=0", lat, rh, rd, h);
        else checks_passed++;
        h   = mk_hdr(e_mem_msg_rd, 40'h80, 3'd3, 16'h0);
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if (rd !== 64'hAA223344AB667788) $display("FAIL other_nowrite: got %h want %h", rd, 64'hAA223344AB667788);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        bp_bedrock_mem_msg_header_s hw_c, hr_c;
        logic [63:0] dw, exp;
        dw   = {$urandom, $urandom};
        hw_c = mk_hdr(e_mem_msg_wr, 40'h28, 3'd3, 16'h1);
        hr_c = mk_hdr(e_mem_msg_rd, 40'h28, 3'd3, 16'h2);
        exp  = model_apply(hw_c, dw);
        exp  = model_apply(hr_c, 64'h0);
        @(negedge clk_i);
        mem_cmd_header_i = hw_c; mem_cmd_data_i = dw; mem_cmd_v_i = 1'b1; mem_resp_ready_and_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checks_total++;
        if ({mem_resp_v_o, mem_resp_header_o} !== {1'b1, hw_c})
            $display("FAIL b2b_wr: got v=%0b hdr=%h want v=1 hdr=%h", mem_resp_v_o, mem_resp_header_o, hw_c);
        else checks_passed++;
        mem_cmd_header_i = hr_c; mem_cmd_data_i = '0;
        #1;
        checks_total++;
        if (mem_cmd_ready_and_o !== 1'b1) $display("FAIL b2b_ready: got %b want 1", mem_cmd_ready_and_o);
        else checks_passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_cmd_v_i = 1'b0;
        checks_total++;
        if ({mem_resp_v_o, mem_resp_header_o, mem_resp_data_o} !== {1'b1, hr_c, exp})
            $display("FAIL b2b_raw: got v=%0b hdr=%h data=%h want v=1 hdr=%h data=%h",
                     mem_resp_v_o, mem_resp_header_o, mem_resp_data_o, hr_c, exp);
        else checks_passed++;
        @(negedge clk_i);
        checks_total++;
        if (mem_resp_v_o !== 1'b0) $display("FAIL b2b_idle: got v=%b want 0", mem_resp_v_o);
        else checks_passed++;
    endtask

    task automatic test_backpressure();
        bp_bedrock_mem_msg_header_s ha, hb;
        logic [63:0] exp_a, exp_b;
        ha    = mk_hdr(e_mem_msg_rd, 40'h80, 3'd3, 16'hA);
        hb    = mk_hdr(e_mem_msg_uc_rd, 40'h84, 3'd1, 16'hB);
        exp_a = model_apply(ha, 64'h0);
        exp_b = model_apply(hb, 64'h0);
        @(negedge clk_i);
        mem_cmd_header_i = ha; mem_cmd_data_i = '0; mem_cmd_v_i = 1'b1; mem_resp_ready_and_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_cmd_header_i = hb;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks_total++;
            if ({mem_cmd_ready_and_o, mem_resp_v_o, mem_resp_header_o, mem_resp_data_o} !== {1'b0, 1'b1, ha, exp_a})
                $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b hdr=%h data=%h want rdy=0 v=1 hdr=%h data=%h",
                         k, mem_cmd_ready_and_o, mem_resp_v_o, mem_resp_header_o, mem_resp_data_o, ha, exp_a);
            else checks_passed++;
            @(negedge clk_i);
        end
        mem_resp_ready_and_i = 1'b1;
        #1;
        checks_total++;
        if (mem_cmd_ready_and_o !== 1'b1) $display("FAIL bp_release: got rdy=%b want 1", mem_cmd_ready_and_o);
        else checks_passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_cmd_v_i = 1'b0;
        checks_total++;
        if ({mem_resp_v_o, mem_resp_header_o, mem_resp_data_o} !== {1'b1, hb, exp_b})
            $display("FAIL bp_second: got v=%0b hdr=%h data=%h want v=1 hdr=%h data=%h",
                     mem_resp_v_o, mem_resp_header_o, mem_resp_data_o, hb, exp_b);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] rd, exp;
        bit lat;
        h = mk_hdr(e_mem_msg_rd, 40'h80, 3'd3, 16'h0);
        @(negedge clk_i);
        mem_cmd_header_i = h; mem_cmd_v_i = 1'b1; mem_resp_ready_and_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_cmd_v_i = 1'b0;
        #1;
        checks_total++;
        if (mem_resp_v_o !== 1'b1) $display("FAIL rstmid_pre: got v=%b want 1", mem_resp_v_o);
        else checks_passed++;
        reset_n_i = 1'b0;
        #1;
        checks_total++;
        if ({mem_resp_v_o, mem_cmd_ready_and_o} !== 2'b01)
            $display("FAIL rstmid_async: got v=%0b rdy=%0b want v=0 rdy=1", mem_resp_v_o, mem_cmd_ready_and_o);
        else checks_passed++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        checks_total++;
        if ({mem_resp_v_o, mem_cmd_ready_and_o} !== 2'b01)
            $display("FAIL rstmid_after: got v=%0b rdy=%0b want v=0 rdy=1", mem_resp_v_o, mem_cmd_ready_and_o);
        else checks_passed++;
        exp = model_apply(h, 64'h0);
        do_txn(h, 64'h0, rh, rd, lat);
        checks_total++;
        if ({lat, rd} !== {1'b1, exp}) $display("FAIL rstmid_keep: got v=%0b data=%h want v=1 data=%h", lat, rd, exp);
        else checks_passed++;
    endtask

    task automatic test_random();
        bp_bedrock_mem_msg_header_s h, rh;
        logic [63:0] d, rd, exp;
        bit lat;
        for (int n = 0; n < 300; n++) begin
            h   = mk_hdr(bp_bedrock_mem_type_e'($urandom_range(0, 5)), 40'({$urandom, $urandom}),
                         3'($urandom_range(0, 7)), 16'($urandom));
            d   = {$urandom, $urandom};
            exp = model_apply(h, d);
            do_txn(h, d, rh, rd, lat);
            checks_total++;
            if ({lat, rh, rd} !== {1'b1, h, exp})
                $display("FAIL rand[%0d]: got v=%0b hdr=%h data=%h want v=1 hdr=%h data=%h", n, lat, rh, rd, h, exp);
            else checks_passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_subword();
        test_alias_overflow();
        test_other_type();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
